// File: rtl/segre_mem_arbiter_if.sv
// Store-size enum shared by the arbiter, its interface and its users. The
// segre_mem_arbiter_if interface then bundles every requester and memory
// signal of the arbiter.
//   master modport : arbiter side. It samples requests and mm_* completion,
//                    and drives *_done_o, the fill lines and the mm_* request.
//   slave modport  : environment side (caches and main memory).
// Signals carry the core-level pin names so that they map 1:1 onto the core.
package segre_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEMOP_BYTE = 2'd0,
        MEMOP_HALF = 2'd1,
        MEMOP_WORD = 2'd2
    } memop_data_type_e;

endpackage

interface segre_mem_arbiter_if #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LANE_SIZE = 128
);
    import segre_mem_arbiter_pkg::*;

    // I$ line fill
    logic                  ic_req_i;
    logic [ADDR_SIZE-1:0]  ic_addr_i;
    logic                  ic_done_o;
    logic [LANE_SIZE-1:0]  ic_data_o;

    // D$ line fill
    logic                  dc_rd_req_i;
    logic [ADDR_SIZE-1:0]  dc_rd_addr_i;
    logic                  dc_rd_done_o;
    logic [LANE_SIZE-1:0]  dc_data_o;

    // D$ write-through store
    logic                  dc_wr_req_i;
    logic [ADDR_SIZE-1:0]  dc_wr_addr_i;
    logic [WORD_SIZE-1:0]  dc_wr_data_i;
    memop_data_type_e      dc_wr_type_i;
    logic                  dc_wr_done_o;

    // Main-memory port
    logic                  mm_rd_o;
    logic                  mm_wr_o;
    logic [ADDR_SIZE-1:0]  mm_addr_o;
    logic [ADDR_SIZE-1:0]  mm_wr_addr_o;
    logic [WORD_SIZE-1:0]  mm_wr_data_o;
    memop_data_type_e      mm_wr_data_type_o;
    logic                  mm_data_rdy_i;
    logic [LANE_SIZE-1:0]  mm_rd_data_i;

    modport master (
        input  ic_req_i, ic_addr_i,
        output ic_done_o, ic_data_o,
        input  dc_rd_req_i, dc_rd_addr_i,
        output dc_rd_done_o, dc_data_o,
        input  dc_wr_req_i, dc_wr_addr_i, dc_wr_data_i, dc_wr_type_i,
        output dc_wr_done_o,
        output mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o,
        input  mm_data_rdy_i, mm_rd_data_i
    );

    modport slave (
        output ic_req_i, ic_addr_i,
        input  ic_done_o, ic_data_o,
        output dc_rd_req_i, dc_rd_addr_i,
        input  dc_rd_done_o, dc_data_o,
        output dc_wr_req_i, dc_wr_addr_i, dc_wr_data_i, dc_wr_type_i,
        input  dc_wr_done_o,
        input  mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o,
        output mm_data_rdy_i, mm_rd_data_i
    );

endinterface

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: serialises the single main-memory port between the I$
// line fill, the D$ line fill and the D$ write-through store. One transaction
// is in flight at a time. A pending store always wins, so that a store is
// ordered ahead of any data read.
//   clk_i  : core clock
//   rsn_i  : synchronous, active-high reset
//   bus    : segre_mem_arbiter_if.master. It carries the requester handshakes
//            (*_req_i / *_done_o / line data) and the mm_* memory pins.
// Build option SEGRE_ARB_RR_EN: when defined, D$ and I$ fills alternate through
// a 1-bit round-robin pointer. When undefined, a D$ fill beats an I$ fill.
// All outputs are registered. Request inputs are only sampled in IDLE.
module segre_mem_arbiter
    import segre_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LANE_SIZE = 128
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    segre_mem_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IC_RD = 3'd1,
        DC_RD = 3'd2,
        DC_WR = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;

    logic [ADDR_SIZE-1:0]  rd_addr_q;
    logic [ADDR_SIZE-1:0]  wr_addr_q;
    logic [WORD_SIZE-1:0]  wr_data_q;
    memop_data_type_e      wr_type_q;
    logic [LANE_SIZE-1:0]  line_q;

    logic                  mm_rd_q, mm_wr_q;
    logic                  ic_done_q, dc_rd_done_q, dc_wr_done_q;

    logic                  ic_first_c;   // I$ fill beats D$ fill this IDLE cycle
    logic                  fill_end_c;   // a fill completes at this edge

    // Fill arbitration between I$ and D$.
`ifdef SEGRE_ARB_RR_EN
    logic                  rr_ptr_q;     // 0: I$ favoured, 1: D$ favoured

    // The pointer flips as a fill completes. This lands during DONE, so the
    // new value governs the next IDLE decision.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            rr_ptr_q <= 1'b0;
        end else if (fill_end_c) begin
            rr_ptr_q <= (state_q == IC_RD);
        end
    end

    assign ic_first_c = ~rr_ptr_q;
`else
    assign ic_first_c = 1'b0;
`endif

    assign fill_end_c = ((state_q == IC_RD) || (state_q == DC_RD)) && bus.mm_data_rdy_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: store first, then fills per the policy above.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.dc_wr_req_i) begin
                    state_d = DC_WR;
                end else if (bus.ic_req_i && (ic_first_c || !bus.dc_rd_req_i)) begin
                    state_d = IC_RD;
                end else if (bus.dc_rd_req_i) begin
                    state_d = DC_RD;
                end
            end
            IC_RD, DC_RD, DC_WR: begin
                if (bus.mm_data_rdy_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches. They are captured on the IDLE grant and held for the
    // whole transaction.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_type_q <= MEMOP_BYTE;
        end else if (state_q == IDLE) begin
            if (state_d == IC_RD) begin
                rd_addr_q <= bus.ic_addr_i;
            end else if (state_d == DC_RD) begin
                rd_addr_q <= bus.dc_rd_addr_i;
            end else if (state_d == DC_WR) begin
                wr_addr_q <= bus.dc_wr_addr_i;
                wr_data_q <= bus.dc_wr_data_i;
                wr_type_q <= bus.dc_wr_type_i;
            end
        end
    end

    // Returned line, captured as the read completes
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            line_q <= '0;
        end else if (fill_end_c) begin
            line_q <= bus.mm_rd_data_i;
        end
    end

    // Registered handshake outputs, derived from the next state
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            mm_rd_q      <= 1'b0;
            mm_wr_q      <= 1'b0;
            ic_done_q    <= 1'b0;
            dc_rd_done_q <= 1'b0;
            dc_wr_done_q <= 1'b0;
        end else begin
            mm_rd_q      <= (state_d == IC_RD) || (state_d == DC_RD);
            mm_wr_q      <= (state_d == DC_WR);
            ic_done_q    <= (state_q == IC_RD) && (state_d == DONE);
            dc_rd_done_q <= (state_q == DC_RD) && (state_d == DONE);
            dc_wr_done_q <= (state_q == DC_WR) && (state_d == DONE);
        end
    end

    assign bus.mm_rd_o           = mm_rd_q;
    assign bus.mm_wr_o           = mm_wr_q;
    assign bus.mm_addr_o         = rd_addr_q;
    assign bus.mm_wr_addr_o      = wr_addr_q;
    assign bus.mm_wr_data_o      = wr_data_q;
    assign bus.mm_wr_data_type_o = wr_type_q;

    assign bus.ic_done_o    = ic_done_q;
    assign bus.dc_rd_done_o = dc_rd_done_q;
    assign bus.dc_wr_done_o = dc_wr_done_q;
    assign bus.ic_data_o    = line_q;
    assign bus.dc_data_o    = line_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter. The stimulus pushes the expected
// memory issues and done pulses into queues. A negedge monitor pops and checks
// them whenever the DUT starts a memory request or pulses a done. A small
// memory model answers requests after a programmable number of cycles. Its
// line is A5A5A5A5 ^ (addr - 0x100), replicated four times.
module tb_segre_mem_arbiter;
    import segre_mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned LW = 128;

    logic clk = 1'b0;
    logic rsn = 1'b1;
    always #5 clk = ~clk;

    segre_mem_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)) bus ();

    segre_mem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus)
    );

    typedef struct {
        logic             is_wr;
        logic [AW-1:0]    addr;
        logic [WW-1:0]    data;
        memop_data_type_e dtype;
    } issue_t;

    typedef struct {
        int            kind;   // 0: I$ fill, 1: D$ fill, 2: store
        logic [LW-1:0] line;
    } done_t;

    issue_t iss_q[$];
    done_t  done_q[$];
    int     checks = 0;
    int     errors = 0;

    // Memory model
    int   mem_delay = 4;
    int   mem_cnt   = 0;
    logic rdy_auto  = 1'b0;
    logic rdy_man   = 1'b0;
    assign bus.mm_data_rdy_i = rdy_auto | rdy_man;

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'hA5A5_A5A5 ^ (a - 32'h100);
        return {w, w, w, w};
    endfunction

    initial bus.mm_rd_data_i = '0;

    always @(negedge clk) begin
        if (rdy_auto) begin
            rdy_auto = 1'b0;
            mem_cnt  = 0;
        end else if (bus.mm_rd_o || bus.mm_wr_o) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_delay) begin
                rdy_auto         = 1'b1;
                bus.mm_rd_data_i = line_for(bus.mm_addr_o);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Scoreboard monitor
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin : monitor
        issue_t        ei;
        done_t         ed;
        int            nd;
        int            gk;
        logic [LW-1:0] gl;
        logic          ok;
        if ((bus.mm_rd_o && !prev_rd) || (bus.mm_wr_o && !prev_wr)) begin
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got rd=%0b wr=%0b addr=%h waddr=%h",
                         bus.mm_rd_o, bus.mm_wr_o, bus.mm_addr_o, bus.mm_wr_addr_o);
            end else begin
                ei = iss_q.pop_front();
                if (ei.is_wr)
                    ok = bus.mm_wr_o && !bus.mm_rd_o && (bus.mm_wr_addr_o == ei.addr) &&
                         (bus.mm_wr_data_o == ei.data) && (bus.mm_wr_data_type_o == ei.dtype);
                else
                    ok = bus.mm_rd_o && !bus.mm_wr_o && (bus.mm_addr_o == ei.addr);
                if (!ok) begin
                    errors++;
                    $display("FAIL issue got rd=%0b wr=%0b raddr=%h waddr=%h wdata=%h wtype=%0d exp wr=%0b addr=%h data=%h type=%0d",
                             bus.mm_rd_o, bus.mm_wr_o, bus.mm_addr_o, bus.mm_wr_addr_o,
                             bus.mm_wr_data_o, bus.mm_wr_data_type_o,
                             ei.is_wr, ei.addr, ei.data, ei.dtype);
                end
            end
        end
        prev_rd = bus.mm_rd_o;
        prev_wr = bus.mm_wr_o;

        nd = int'(bus.ic_done_o) + int'(bus.dc_rd_done_o) + int'(bus.dc_wr_done_o);
        if (nd != 0) begin
            checks++;
            gk = bus.ic_done_o ? 0 : (bus.dc_rd_done_o ? 1 : 2);
            gl = bus.ic_done_o ? bus.ic_data_o : bus.dc_data_o;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got kind=%0d count=%0d", gk, nd);
            end else begin
                ed = done_q.pop_front();
                if (nd != 1 || gk != ed.kind || (gk != 2 && gl != ed.line)) begin
                    errors++;
                    $display("FAIL done got kind=%0d count=%0d line=%h exp kind=%0d line=%h",
                             gk, nd, gl, ed.kind, ed.line);
                end
            end
        end
    end

    task automatic push_rd(input logic [AW-1:0] a);
        issue_t e;
        e.is_wr = 1'b0; e.addr = a; e.data = '0; e.dtype = MEMOP_BYTE;
        iss_q.push_back(e);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [WW-1:0] d, input memop_data_type_e t);
        issue_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d; e.dtype = t;
        iss_q.push_back(e);
    endtask

    task automatic push_done(input int k, input logic [LW-1:0] l);
        done_t e;
        e.kind = k; e.line = l;
        done_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Returns on the negedge where the n-th done pulse is visible.
    task automatic wait_done(input string name, input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.ic_done_o || bus.dc_rd_done_o || bus.dc_wr_done_o) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL %s_timeout got=%0d dones exp=%0d", name, seen, n);
        end
    endtask

    task automatic chk_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({name, "_done"}, LW'({bus.ic_done_o, bus.dc_rd_done_o, bus.dc_wr_done_o}), '0);
            chk({name, "_mm"}, LW'({bus.mm_rd_o, bus.mm_wr_o}), '0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ic_req_i     = 1'b0; bus.ic_addr_i   = '0;
        bus.dc_rd_req_i  = 1'b0; bus.dc_rd_addr_i = '0;
        bus.dc_wr_req_i  = 1'b0; bus.dc_wr_addr_i = '0;
        bus.dc_wr_data_i = '0;   bus.dc_wr_type_i = MEMOP_WORD;

        // Reset state
        rsn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mm", LW'({bus.mm_rd_o, bus.mm_wr_o}), '0);
        chk("rst_done", LW'({bus.ic_done_o, bus.dc_rd_done_o, bus.dc_wr_done_o}), '0);
        chk("rst_addr", LW'(bus.mm_addr_o), '0);
        chk("rst_wr_bus", LW'({bus.mm_wr_addr_o, bus.mm_wr_data_o, bus.mm_wr_data_type_o}), '0);
        chk("rst_line", bus.ic_data_o, '0);
        rsn = 1'b0;
        @(negedge clk);

        // Single I$ fill, rdy at cycle 4, done at cycle 5
        mem_delay = 4;
        bus.ic_addr_i = 32'h0000_0100; bus.ic_req_i = 1'b1;
        push_rd(32'h0000_0100);
        push_done(0, {4{32'hA5A5_A5A5}});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t1_mm_rd_c%0d", k), LW'(bus.mm_rd_o), LW'(k <= 4));
            chk($sformatf("t1_ic_done_c%0d", k), LW'(bus.ic_done_o), LW'(k == 5));
            if (k == 1) chk("t1_addr", LW'(bus.mm_addr_o), LW'(32'h100));
            if (k == 5) bus.ic_req_i = 1'b0;
        end

        // Store and D$ fill of the same address in one cycle: store first
        mem_delay = 2;
        bus.dc_wr_addr_i = 32'h200; bus.dc_wr_data_i = 32'h1234_5678;
        bus.dc_wr_type_i = MEMOP_WORD; bus.dc_wr_req_i = 1'b1;
        bus.dc_rd_addr_i = 32'h200; bus.dc_rd_req_i = 1'b1;
        push_wr(32'h200, 32'h1234_5678, MEMOP_WORD);
        push_rd(32'h200);
        push_done(2, '0);
        push_done(1, {4{32'hA5A5_A4A5}});
        wait_done("t2_wr", 1, 20);
        bus.dc_wr_req_i = 1'b0;
        wait_done("t2_rd", 1, 20);
        bus.dc_rd_req_i = 1'b0;

        // Byte store alone
        @(negedge clk);
        bus.dc_wr_addr_i = 32'h203; bus.dc_wr_data_i = 32'h0000_00AB;
        bus.dc_wr_type_i = MEMOP_BYTE; bus.dc_wr_req_i = 1'b1;
        push_wr(32'h203, 32'h0000_00AB, MEMOP_BYTE);
        push_done(2, '0);
        wait_done("t3_wr", 1, 20);
        bus.dc_wr_req_i = 1'b0;

        // rdy while idle is ignored
        @(negedge clk);
        rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        chk_quiet("t4_idle_rdy", 3);

        // rdy in the first request cycle: done two cycles after the request
        mem_delay = 1;
        bus.dc_rd_addr_i = 32'h400; bus.dc_rd_req_i = 1'b1;
        push_rd(32'h400);
        push_done(1, {4{32'hA5A5_A6A5}});
        @(negedge clk);
        chk("t5_mm_rd_c1", LW'(bus.mm_rd_o), LW'(1));
        @(negedge clk);
        chk("t5_done_c2", LW'(bus.dc_rd_done_o), LW'(1));
        bus.dc_rd_req_i = 1'b0;
        @(negedge clk);
        chk("t5_done_c3", LW'(bus.dc_rd_done_o), LW'(0));

        // I$ and D$ fills both held for four transactions
        mem_delay = 2;
        bus.ic_addr_i = 32'h1000; bus.ic_req_i = 1'b1;
        bus.dc_rd_addr_i = 32'h2000; bus.dc_rd_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SEGRE_ARB_RR_EN
            if (i % 2 == 0) begin
                push_rd(32'h1000);
                push_done(0, {4{32'hA5A5_AAA5}});
            end else begin
                push_rd(32'h2000);
                push_done(1, {4{32'hA5A5_BAA5}});
            end
`else
            push_rd(32'h2000);
            push_done(1, {4{32'hA5A5_BAA5}});
`endif
        end
        wait_done("t6_held", 4, 60);
        bus.ic_req_i = 1'b0; bus.dc_rd_req_i = 1'b0;

        // Reset during a D$ fill: request drops, no done, late rdy ignored
        @(negedge clk);
        mem_delay = 50;
        bus.dc_rd_addr_i = 32'h3000; bus.dc_rd_req_i = 1'b1;
        push_rd(32'h3000);
        repeat (3) @(negedge clk);
        chk("t7_mm_rd_busy", LW'(bus.mm_rd_o), LW'(1));
        rsn = 1'b1; bus.dc_rd_req_i = 1'b0;
        @(negedge clk);
        chk("t7_mm_rd_reset", LW'(bus.mm_rd_o), LW'(0));
        chk("t7_done_reset", LW'(bus.dc_rd_done_o), LW'(0));
        chk("t7_addr_reset", LW'(bus.mm_addr_o), '0);
        rsn = 1'b0;
        rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        chk_quiet("t7_after", 3);

        // Recovery: plain I$ fill after the abort
        mem_delay = 3;
        bus.ic_addr_i = 32'h500; bus.ic_req_i = 1'b1;
        push_rd(32'h500);
        push_done(0, {4{32'hA5A5_A1A5}});
        wait_done("t8_ic", 1, 20);
        bus.ic_req_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("end_issue_queue", LW'(iss_q.size()), '0);
        chk("end_done_queue", LW'(done_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
